// File: rtl/chip_emu_pkg.sv
// ============================================================================
// Module      : chip_emu_pkg
// Description : Shared types, constants and the per-gate fault function for
//               the 7404 hex-inverter emulator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package chip_emu_pkg;

    localparam int NUM_GATES = 6;

    typedef enum logic [1:0] {
        FM_NONE   = 2'd0,
        FM_STUCK0 = 2'd1,
        FM_STUCK1 = 2'd2,
        FM_BUFFER = 2'd3
    } fault_mode_t;

    typedef enum logic [1:0] {
        Off     = 2'd0,
        PowerUp = 2'd1,
        Active  = 2'd2
    } emu_state_t;

    function automatic logic apply_fault(input fault_mode_t mode, input logic a);
        case (mode)
            FM_STUCK0: return 1'b0;
            FM_STUCK1: return 1'b1;
            FM_BUFFER: return a;
            default:   return ~a;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/emu_delay_line.sv
// ============================================================================
// Module      : emu_delay_line
// Description : WIDTH-bit shift register of DEPTH stages with synchronous flush.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module emu_delay_line #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/chip_7404_emulator.sv
// ============================================================================
// Module      : chip_7404_emulator
// Description : Clocked 7404 hex-inverter model with power-up sequencing and
//               per-gate fault injection. Edge counter built only when
//               CHIP_EMU_EDGE_COUNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module chip_7404_emulator
    import chip_emu_pkg::*;
#(
    parameter int DELAY_CYCLES = 2,
    parameter int PWRUP_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Pin1,
    input  logic        Pin3,
    input  logic        Pin5,
    input  logic        Pin9,
    input  logic        Pin11,
    input  logic        Pin13,
    output logic        Pin2,
    output logic        Pin4,
    output logic        Pin6,
    output logic        Pin8,
    output logic        Pin10,
    output logic        Pin12,
    input  logic [2:0]  Fault_Sel,
    input  logic [1:0]  Fault_Mode,
    input  logic        Fault_Load,
    output logic        Live,
    output logic [15:0] Edge_Count
);

    localparam logic [7:0] C_PWR_LAST = 8'(PWRUP_CYCLES - 1);

    logic [NUM_GATES-1:0] w_a;
    logic [NUM_GATES-1:0] w_last;
    logic [NUM_GATES-1:0] w_y;
    logic                 w_flush;
    emu_state_t           r_state;
    logic                 r_live;
    logic [7:0]           r_pwr_cnt;
    fault_mode_t          r_fault [NUM_GATES];

    assign w_a     = {Pin13, Pin11, Pin9, Pin5, Pin3, Pin1};
    assign w_flush = (r_state != Active);

    emu_delay_line #(
        .WIDTH (NUM_GATES),
        .DEPTH (DELAY_CYCLES)
    ) u_delay (
        .clk   (Clk),
        .rst   (Reset),
        .flush (w_flush),
        .din   (w_a),
        .dout  (w_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= Off;
            r_live    <= 1'b0;
            r_pwr_cnt <= '0;
        end else begin
            case (r_state)
                Off: begin
                    if (Enable) begin
                        r_state   <= PowerUp;
                        r_pwr_cnt <= '0;
                    end
                end
                PowerUp: begin
                    if (!Enable) begin
                        r_state <= Off;
                    end else if (r_pwr_cnt == C_PWR_LAST) begin
                        r_state <= Active;
                        r_live  <= 1'b1;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 8'd1;
                    end
                end
                Active: begin
                    if (!Enable) begin
                        r_state <= Off;
                        r_live  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= Off;
                    r_live  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range selects are dropped silently.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_GATES; i++) begin
                r_fault[i] <= FM_NONE;
            end
        end else if (Fault_Load && (Fault_Sel < 3'(NUM_GATES))) begin
            r_fault[Fault_Sel] <= fault_mode_t'(Fault_Mode);
        end
    end

    // The last delay stage is the output register; faults act on it directly.
    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        assign w_y[g] = r_live ? apply_fault(r_fault[g], w_last[g]) : 1'b0;
    end

    assign Pin2  = w_y[0];
    assign Pin4  = w_y[1];
    assign Pin6  = w_y[2];
    assign Pin8  = w_y[3];
    assign Pin10 = w_y[4];
    assign Pin12 = w_y[5];
    assign Live  = r_live;

`ifdef CHIP_EMU_EDGE_COUNT_EN
    logic [NUM_GATES-1:0] r_prev;
    logic [15:0]          r_edge_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev     <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_prev <= w_a;
            if ((r_state == Off) && Enable) begin
                r_edge_cnt <= '0;
            end else if ((r_state == Active) && (w_a != r_prev) && (r_edge_cnt != 16'hFFFF)) begin
                r_edge_cnt <= r_edge_cnt + 16'd1;
            end
        end
    end

    assign Edge_Count = r_edge_cnt;
`else
    assign Edge_Count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chip_7404_emulator.sv
// ============================================================================
// Module      : tb_chip_7404_emulator
// Description : Self-checking bench for chip_7404_emulator against a
//               cycle-level behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chip_7404_emulator;

    localparam int DLY = 2;
    localparam int PWR = 4;
    localparam int M_OFF = 0, M_PWR = 1, M_ACT = 2;
`ifdef CHIP_EMU_EDGE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [5:0]  a = 6'h00;
    logic [2:0]  Fault_Sel = 3'd0;
    logic [1:0]  Fault_Mode = 2'd0;
    logic        Fault_Load = 1'b0;
    logic        Pin2, Pin4, Pin6, Pin8, Pin10, Pin12;
    logic        Live;
    logic [15:0] Edge_Count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_mode = M_OFF;
    int         m_pw = 0;
    logic [5:0] m_pipe [$];
    int         m_fault [6];
    int         m_cnt = 0;
    logic [5:0] m_prev = 6'h00;

    chip_7404_emulator #(.DELAY_CYCLES(DLY), .PWRUP_CYCLES(PWR)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .Pin1       (a[0]),
        .Pin3       (a[1]),
        .Pin5       (a[2]),
        .Pin9       (a[3]),
        .Pin11      (a[4]),
        .Pin13      (a[5]),
        .Pin2       (Pin2),
        .Pin4       (Pin4),
        .Pin6       (Pin6),
        .Pin8       (Pin8),
        .Pin10      (Pin10),
        .Pin12      (Pin12),
        .Fault_Sel  (Fault_Sel),
        .Fault_Mode (Fault_Mode),
        .Fault_Load (Fault_Load),
        .Live       (Live),
        .Edge_Count (Edge_Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [5:0] dut_y();
        return {Pin12, Pin10, Pin8, Pin6, Pin4, Pin2};
    endfunction

    function automatic logic [5:0] exp_y();
        logic [5:0] y;
        logic [5:0] last;
        y = 6'h00;
        last = m_pipe[DLY-1];
        if (m_mode == M_ACT) begin
            for (int i = 0; i < 6; i++) begin
                case (m_fault[i])
                    1: y[i] = 1'b0;
                    2: y[i] = 1'b1;
                    3: y[i] = last[i];
                    default: y[i] = ~last[i];
                endcase
            end
        end
        return y;
    endfunction

    // One clock: capture pre-edge inputs, advance model, settle 1 time unit.
    task automatic tick();
        logic       r  = Reset;
        logic       e  = Enable;
        logic       fl = Fault_Load;
        logic [5:0] av = a;
        int         fs = int'(Fault_Sel);
        int         fm = int'(Fault_Mode);
        @(posedge Clk);
        if (r) begin
            m_mode = M_OFF;
            m_pw   = 0;
            m_pipe = {};
            repeat (DLY) m_pipe.push_back(6'h00);
            foreach (m_fault[i]) m_fault[i] = 0;
            m_cnt  = 0;
            m_prev = 6'h00;
        end else begin
            m_pipe.push_front((m_mode == M_ACT) ? av : 6'h00);
            void'(m_pipe.pop_back());
            if (CNT_ON) begin
                if (m_mode == M_OFF && e) m_cnt = 0;
                else if (m_mode == M_ACT && av != m_prev && m_cnt < 65535) m_cnt++;
            end
            m_prev = av;
            if (fl && fs < 6) m_fault[fs] = fm;
            case (m_mode)
                M_OFF: if (e) begin m_mode = M_PWR; m_pw = PWR; end
                M_PWR: begin
                    if (!e) m_mode = M_OFF;
                    else begin
                        m_pw--;
                        if (m_pw == 0) m_mode = M_ACT;
                    end
                end
                default: if (!e) m_mode = M_OFF;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (dut_y() !== 6'h00) begin n_bad++; $display("FAIL reset_y: got %h want %h", dut_y(), 6'h00); end
        n_cmp++; if (Live !== 1'b0) begin n_bad++; $display("FAIL reset_live: got %b want 0", Live); end
        n_cmp++; if (Edge_Count !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", Edge_Count); end
        Reset = 1'b0;
    endtask

    task automatic test_powerup();
        Enable = 1'b1;
        a = 6'h00;
        tick();
        for (int k = 1; k <= PWR; k++) begin
            tick();
            n_cmp++; if (Live !== (k == PWR)) begin n_bad++; $display("FAIL pwrup_live k=%0d: got %b want %b", k, Live, (k == PWR)); end
        end
        n_cmp++; if (dut_y() !== 6'h3F) begin n_bad++; $display("FAIL pwrup_first_y: got %h want 3f", dut_y()); end
        tick();
        tick();
        n_cmp++; if (dut_y() !== 6'h3F) begin n_bad++; $display("FAIL pwrup_y: got %h want 3f", dut_y()); end
    endtask

    task automatic test_invert();
        int cnt0;
        cnt0 = m_cnt;
        a = 6'h2A;
        tick();
        n_cmp++; if (dut_y() !== 6'h3F) begin n_bad++; $display("FAIL inv_early: got %h want 3f", dut_y()); end
        tick();
        n_cmp++; if (dut_y() !== 6'h15) begin n_bad++; $display("FAIL inv_y: got %h want 15", dut_y()); end
        n_cmp++; if (Edge_Count !== 16'(CNT_ON ? cnt0 + 1 : 0)) begin n_bad++; $display("FAIL inv_cnt: got %0d want %0d", Edge_Count, CNT_ON ? cnt0 + 1 : 0); end
    endtask

    task automatic test_fault();
        Fault_Sel = 3'd3; Fault_Mode = 2'd1; Fault_Load = 1'b1; a = 6'h00;
        tick();
        Fault_Load = 1'b0;
        tick();
        n_cmp++; if (dut_y() !== 6'h37) begin n_bad++; $display("FAIL fault_stuck0: got %h want 37", dut_y()); end
        Fault_Mode = 2'd0; Fault_Load = 1'b1;
        tick();
        Fault_Load = 1'b0;
        n_cmp++; if (dut_y() !== 6'h3F) begin n_bad++; $display("FAIL fault_next_cycle: got %h want 3f", dut_y()); end
        Fault_Mode = 2'd3; Fault_Load = 1'b1; a = 6'h08;
        tick();
        Fault_Load = 1'b0;
        n_cmp++; if (dut_y() !== 6'h37) begin n_bad++; $display("FAIL fault_buf_old: got %h want 37", dut_y()); end
        tick();
        n_cmp++; if (Pin8 !== 1'b1 || dut_y() !== 6'h3F) begin n_bad++; $display("FAIL fault_buffer: got %h want 3f", dut_y()); end
    endtask

    task automatic test_abort();
        bit seen_live;
        seen_live = 1'b0;
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        tick();
        tick();
        Enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen_live |= Live;
        end
        n_cmp++; if (seen_live !== 1'b0) begin n_bad++; $display("FAIL abort_live: got 1 want 0"); end
        n_cmp++; if (dut_y() !== 6'h00) begin n_bad++; $display("FAIL abort_y: got %h want 00", dut_y()); end
        Enable = 1'b1; a = 6'h00;
        repeat (PWR + 1) tick();
        n_cmp++; if (Live !== 1'b1) begin n_bad++; $display("FAIL abort_relive: got %b want 1", Live); end
        n_cmp++; if (dut_y() !== 6'h37) begin n_bad++; $display("FAIL abort_fault_kept: got %h want 37", dut_y()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            a          = 6'($urandom);
            Enable     = ($urandom_range(0, 15) != 0);
            Fault_Load = ($urandom_range(0, 3) == 0);
            Fault_Sel  = 3'($urandom_range(0, 7));
            Fault_Mode = 2'($urandom);
            tick();
            n_cmp++; if (dut_y() !== exp_y()) begin n_bad++; $display("FAIL rand_y k=%0d: got %h want %h", k, dut_y(), exp_y()); end
            n_cmp++; if (Live !== (m_mode == M_ACT)) begin n_bad++; $display("FAIL rand_live k=%0d: got %b want %b", k, Live, (m_mode == M_ACT)); end
            n_cmp++; if (Edge_Count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_cnt k=%0d: got %0d want %0d", k, Edge_Count, m_cnt); end
        end
        Fault_Load = 1'b0;
        Enable = 1'b1;
    endtask

    task automatic test_saturate();
        int guard;
        guard = 0;
        while (m_mode != M_ACT && guard < 12) begin
            tick();
            guard++;
        end
        n_cmp++; if (Live !== 1'b1) begin n_bad++; $display("FAIL sat_reach_active: got %b want 1", Live); end
        for (int k = 0; k < 70000; k++) begin
            a = ~a;
            tick();
        end
        n_cmp++; if (Edge_Count !== (CNT_ON ? 16'hFFFF : 16'h0000)) begin n_bad++; $display("FAIL sat_cnt: got %h want %h", Edge_Count, CNT_ON ? 16'hFFFF : 16'h0000); end
        n_cmp++; if (dut_y() !== exp_y()) begin n_bad++; $display("FAIL sat_y: got %h want %h", dut_y(), exp_y()); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] y_before;
        a = 6'h00;
        tick();
        tick();
        y_before = exp_y();
        Fault_Sel = 3'd7; Fault_Mode = 2'd2; Fault_Load = 1'b1;
        tick();
        Fault_Load = 1'b0;
        tick();
        n_cmp++; if (dut_y() !== y_before) begin n_bad++; $display("FAIL sel7_ignored: got %h want %h", dut_y(), y_before); end
        Reset = 1'b1;
        tick();
        n_cmp++; if (Live !== 1'b0) begin n_bad++; $display("FAIL midrst_live: got %b want 0", Live); end
        n_cmp++; if (dut_y() !== 6'h00) begin n_bad++; $display("FAIL midrst_y: got %h want 00", dut_y()); end
        n_cmp++; if (Edge_Count !== 16'h0000) begin n_bad++; $display("FAIL midrst_cnt: got %h want 0000", Edge_Count); end
        Reset = 1'b0;
        repeat (PWR + 1 + DLY) tick();
        n_cmp++; if (dut_y() !== 6'h3F) begin n_bad++; $display("FAIL midrst_faults_cleared: got %h want 3f", dut_y()); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_invert();
        test_fault();
        test_abort();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
